// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - state encoding and constants shared by the SUBLEQ sequencer and control decoder
package subleq_pkg;

    localparam int ST_W    = 4;
    localparam int PC_STEP = 3;

    localparam logic [ST_W-1:0] ST_FETCH_A     = 4'd0;
    localparam logic [ST_W-1:0] ST_LOAD_A      = 4'd1;
    localparam logic [ST_W-1:0] ST_FETCH_B     = 4'd2;
    localparam logic [ST_W-1:0] ST_LOAD_B      = 4'd3;
    localparam logic [ST_W-1:0] ST_FETCH_C     = 4'd4;
    localparam logic [ST_W-1:0] ST_LOAD_C      = 4'd5;
    localparam logic [ST_W-1:0] ST_FETCH_MEM_A = 4'd6;
    localparam logic [ST_W-1:0] ST_LOAD_MEM_A  = 4'd7;
    localparam logic [ST_W-1:0] ST_FETCH_MEM_B = 4'd8;
    localparam logic [ST_W-1:0] ST_LOAD_MEM_B  = 4'd9;
    localparam logic [ST_W-1:0] ST_EXECUTE     = 4'd10;
    localparam logic [ST_W-1:0] ST_WRITEBACK   = 4'd11;
    localparam logic [ST_W-1:0] ST_UPDATE_PC   = 4'd12;
    localparam logic [ST_W-1:0] ST_HALT        = 4'd13;

endpackage

// File: rtl/subleq_addr_mux.sv
// rtl/subleq_addr_mux.sv - per-phase memory address selection
module subleq_addr_mux
    import subleq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ST_W-1:0]   state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] a_val,
    input  logic [ADDR_W-1:0] b_val,
    output logic [ADDR_W-1:0] mem_addr
);

    // Instruction words live at pc, pc+1, pc+2 (wrapping); operand phases use the datapath registers
    always_comb begin
        mem_addr = pc;
        case (state)
            ST_FETCH_B, ST_LOAD_B:         mem_addr = pc + ADDR_W'(1);
            ST_FETCH_C, ST_LOAD_C:         mem_addr = pc + ADDR_W'(2);
            ST_FETCH_MEM_A, ST_LOAD_MEM_A: mem_addr = a_val;
            ST_FETCH_MEM_B, ST_LOAD_MEM_B,
            ST_WRITEBACK:                  mem_addr = b_val;
            default:                       mem_addr = pc;
        endcase
    end

endmodule

// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - master phase FSM, PC, halt latch and retired-instruction counter
module subleq_sequencer
    import subleq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] a_val,
    input  logic [ADDR_W-1:0] b_val,
    input  logic [ADDR_W-1:0] c_val,
    input  logic              zero,
    input  logic              negative,
    output logic [ST_W-1:0]   state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taken;
    logic              halt_branch;

    assign taken       = zero | negative;
    assign halt_branch = taken && (c_val == {ADDR_W{1'b1}});

    // Phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next phase: memory phases wait for mem_ready, internal phases take one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH_A, ST_FETCH_B, ST_FETCH_C,
            ST_FETCH_MEM_A, ST_FETCH_MEM_B: begin
                if (mem_ready) state_d = state_q + 4'd1;
            end
            ST_LOAD_A, ST_LOAD_B, ST_LOAD_C,
            ST_LOAD_MEM_A, ST_LOAD_MEM_B,
            ST_EXECUTE:                     state_d = state_q + 4'd1;
            ST_WRITEBACK: begin
                if (mem_ready) state_d = ST_UPDATE_PC;
            end
            ST_UPDATE_PC:                   state_d = halt_branch ? ST_HALT : ST_FETCH_A;
            ST_HALT:                        state_d = ST_HALT;
            default:                        state_d = ST_FETCH_A;
        endcase
    end

    // Architectural updates happen only in UPDATE_PC; a branch to all-ones means halt
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (state_q == ST_UPDATE_PC) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (halt_branch) begin
                halted_d = 1'b1;
            end else if (taken) begin
                pc_d = c_val;
            end else begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
        end
    end

    // PC, halt flag and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= ADDR_W'(RESET_PC);
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    subleq_addr_mux #(
        .ADDR_W (ADDR_W)
    ) u_addr_mux (
        .state    (state_q),
        .pc       (pc_q),
        .a_val    (a_val),
        .b_val    (b_val),
        .mem_addr (mem_addr)
    );

    assign state       = state_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - directed self-checking bench for subleq_sequencer
module tb_subleq_sequencer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_ready;
    logic [ADDR_W-1:0] a_val, b_val, c_val;
    logic              zero, negative;
    logic [3:0]        state;
    logic [ADDR_W-1:0] mem_addr, pc;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] st;
        logic [7:0] addr;
        logic [7:0] pcv;
    } vec_t;

    vec_t vecs [14];

    subleq_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ready   (mem_ready),
        .a_val       (a_val),
        .b_val       (b_val),
        .c_val       (c_val),
        .zero        (zero),
        .negative    (negative),
        .state       (state),
        .mem_addr    (mem_addr),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input logic [3:0] target);
        int n = 0;
        while (state !== target && n < 60) begin
            step();
            n++;
        end
        chk("reach_state", 32'(state), 32'(target));
    endtask

    initial begin
        vecs[0]  = '{4'd0,  8'h00, 8'h00};
        vecs[1]  = '{4'd1,  8'h00, 8'h00};
        vecs[2]  = '{4'd2,  8'h01, 8'h00};
        vecs[3]  = '{4'd3,  8'h01, 8'h00};
        vecs[4]  = '{4'd4,  8'h02, 8'h00};
        vecs[5]  = '{4'd5,  8'h02, 8'h00};
        vecs[6]  = '{4'd6,  8'h20, 8'h00};
        vecs[7]  = '{4'd7,  8'h20, 8'h00};
        vecs[8]  = '{4'd8,  8'h30, 8'h00};
        vecs[9]  = '{4'd9,  8'h30, 8'h00};
        vecs[10] = '{4'd10, 8'h00, 8'h00};
        vecs[11] = '{4'd11, 8'h30, 8'h00};
        vecs[12] = '{4'd12, 8'h00, 8'h00};
        vecs[13] = '{4'd0,  8'h03, 8'h03};

        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; negative = 1'b0;
        a_val = 8'h20; b_val = 8'h30; c_val = 8'h00;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: fastest instruction, 13 cycles through all phases
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("t1_state[%0d]", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("t1_addr[%0d]", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("t1_pc[%0d]", i), 32'(pc), 32'(vecs[i].pcv));
            if (i < 13) step();
        end
        chk("t1_count", 32'(instr_count), 32'd1);

        // 2: four stall cycles in FETCH_MEM_A
        begin
            int cyc = 0;
            int stalls = 0;
            for (int n = 0; n < 40; n++) begin
                if (state == 4'd6 && stalls < 4) begin
                    mem_ready = 1'b0;
                    chk("t2_hold_state", 32'(state), 32'd6);
                    chk("t2_hold_addr", 32'(mem_addr), 32'h20);
                    stalls++;
                end else begin
                    mem_ready = 1'b1;
                end
                step();
                cyc++;
                if (state == 4'd0) break;
            end
            mem_ready = 1'b1;
            chk("t2_cycles", 32'(cyc), 32'd17);
            chk("t2_stalls", 32'(stalls), 32'd4);
            chk("t2_pc", 32'(pc), 32'h06);
            chk("t2_count", 32'(instr_count), 32'd2);
        end

        // 3: taken branch on negative
        negative = 1'b1; c_val = 8'h40;
        run_to(4'd12);
        chk("t3_addr_upd", 32'(mem_addr), 32'h06);
        step();
        chk("t3_state", 32'(state), 32'd0);
        chk("t3_pc", 32'(pc), 32'h40);
        chk("t3_addr", 32'(mem_addr), 32'h40);
        chk("t3_count", 32'(instr_count), 32'd3);

        // 4: branch to FE, then fall through with wrap
        c_val = 8'hFE;
        run_to(4'd12);
        step();
        chk("t4_pc_fe", 32'(pc), 32'hFE);
        negative = 1'b0;
        chk("t4_addr_fe0", 32'(mem_addr), 32'hFE);
        step(); step();
        chk("t4_addr_fe2", 32'(mem_addr), 32'hFF);
        step(); step();
        chk("t4_addr_fe4", 32'(mem_addr), 32'h00);
        run_to(4'd12);
        step();
        chk("t4_pc_wrap", 32'(pc), 32'h01);
        chk("t4_count", 32'(instr_count), 32'd5);
        chk("t4_addr_0", 32'(mem_addr), 32'h01);
        step(); step();
        chk("t4_addr_2", 32'(mem_addr), 32'h02);
        step(); step();
        chk("t4_addr_4", 32'(mem_addr), 32'h03);

        // 5: halt via zero and branch to all-ones
        zero = 1'b1; c_val = 8'hFF;
        run_to(4'd12);
        step();
        chk("t5_state", 32'(state), 32'd13);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc", 32'(pc), 32'h01);
        chk("t5_count", 32'(instr_count), 32'd6);
        for (int i = 0; i < 100; i++) begin
            mem_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
            chk("t5_absorb", 32'(state), 32'd13);
        end
        chk("t5_pc_end", 32'(pc), 32'h01);
        chk("t5_count_end", 32'(instr_count), 32'd6);

        // 6: asynchronous reset out of halt, then out of a WRITEBACK stall
        rst = 1'b1;
        #1;
        chk("t6_halt_rst_state", 32'(state), 32'd0);
        chk("t6_halt_rst_halted", 32'(halted), 32'd0);
        chk("t6_halt_rst_pc", 32'(pc), 32'd0);
        chk("t6_halt_rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0; zero = 1'b0; c_val = 8'h00; mem_ready = 1'b1;
        run_to(4'd12);
        step();
        chk("t6_pc_pre", 32'(pc), 32'h03);
        run_to(4'd11);
        mem_ready = 1'b0;
        step(); step();
        chk("t6_wb_hold", 32'(state), 32'd11);
        chk("t6_wb_addr", 32'(mem_addr), 32'h30);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_wb_rst_state", 32'(state), 32'd0);
        chk("t6_wb_rst_pc", 32'(pc), 32'd0);
        chk("t6_wb_rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        chk("t6_post_rst", 32'(state), 32'd0);

        // Counter saturation at all-ones
        for (int k = 0; k < 8; k++) begin
            run_to(4'd12);
            step();
            if (k == 6) chk("sat_count7", 32'(instr_count), 32'd7);
        end
        chk("sat_count_hold", 32'(instr_count), 32'd7);
        chk("sat_pc", 32'(pc), 32'h18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
